// File: rtl/i2s_tx.sv
// i2s_tx: stereo PCM to Philips I2S serializer.
// A one-entry holding register accepts a sample pair over valid/ready; at each
// frame boundary the pair moves into per-channel shift registers and is sent
// MSB first, one SCLK after each LRCLK transition. An empty holding register at
// a frame boundary sends a silent frame and raises a one-cycle underrun pulse.
module i2s_tx #(
  parameter int width_p      = 24,
  parameter int frame_bits_p = 32,
  parameter int sclk_div_p   = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic signed [width_p-1:0] data_l_i,
  input  logic signed [width_p-1:0] data_r_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      sclk_o,
  output logic                      lrclk_o,
  output logic                      sdout_o,
  output logic                      underrun_o
);

  localparam int FRAME_LEN = 2 * frame_bits_p;
  localparam int BC_W      = $clog2(FRAME_LEN);
  localparam int DC_W      = $clog2(sclk_div_p);

  localparam logic [DC_W-1:0] DIV_LAST  = DC_W'(sclk_div_p - 1);
  localparam logic [DC_W-1:0] DIV_HALF  = DC_W'(sclk_div_p / 2);
  localparam logic [DC_W-1:0] DIV_ONE   = DC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(FRAME_LEN - 1);
  localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
  localparam logic [BC_W-1:0] BC_RIGHT  = BC_W'(frame_bits_p);
  localparam logic [BC_W-1:0] SLOT_LAST = BC_W'(width_p);

  // Control and serializer state
  logic [DC_W-1:0]           r_div_cnt;
  logic [BC_W-1:0]           r_bit_cnt;
  logic                      r_full;
  logic signed [width_p-1:0] r_hold_l;
  logic signed [width_p-1:0] r_hold_r;
  logic signed [width_p-1:0] r_shift_l;
  logic signed [width_p-1:0] r_shift_r;
  logic                      r_sclk;
  logic                      r_lrclk;
  logic                      r_sdout;
  logic                      r_underrun;

  // Next-state helpers
  logic            w_tick;
  logic [DC_W-1:0] w_div_nxt;
  logic            w_wrap;
  logic [BC_W-1:0] w_bc_nxt;
  logic            w_right_nxt;
  logic [BC_W-1:0] w_slot;
  logic            w_data_slot;
  logic            w_load;
  logic            w_accept;

  // tick marks the last clk of an SCLK period, i.e. the SCLK falling edge
  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign w_div_nxt   = w_tick ? '0 : (r_div_cnt + DIV_ONE);
  assign w_wrap      = (r_bit_cnt == BC_LAST);
  assign w_bc_nxt    = w_wrap ? '0 : (r_bit_cnt + BC_ONE);
  assign w_right_nxt = (w_bc_nxt >= BC_RIGHT);
  // Position inside the current channel slot; slot bit 0 is the I2S one-bit delay
  assign w_slot      = w_right_nxt ? (w_bc_nxt - BC_RIGHT) : w_bc_nxt;
  assign w_data_slot = (w_slot != '0) && (w_slot <= SLOT_LAST);
  assign w_load      = w_tick & w_wrap;

  // ready is held low during reset so nothing is accepted on a reset edge
  assign ready_o  = ~r_full & ~reset_i;
  assign w_accept = valid_i & ready_o;

  assign sclk_o     = r_sclk;
  assign lrclk_o    = r_lrclk;
  assign sdout_o    = r_sdout;
  assign underrun_o = r_underrun;

  // Bit clock generation, frame sequencing, frame load and serial output
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= BC_LAST;
      r_full     <= 1'b0;
      r_sclk     <= 1'b0;
      r_lrclk    <= 1'b1;
      r_sdout    <= 1'b0;
      r_underrun <= 1'b0;
      r_shift_l  <= '0;
      r_shift_r  <= '0;
    end else begin
      r_div_cnt  <= w_div_nxt;
      r_sclk     <= (w_div_nxt >= DIV_HALF);
      r_underrun <= 1'b0;
      if (w_tick) begin
        r_bit_cnt <= w_bc_nxt;
        r_lrclk   <= w_right_nxt;
        if (w_load) begin
          // Frame boundary: slot bit 0, so the line is low while new data loads
          r_sdout <= 1'b0;
          if (r_full) begin
            r_shift_l <= r_hold_l;
            r_shift_r <= r_hold_r;
            r_full    <= 1'b0;
          end else begin
            r_shift_l  <= '0;
            r_shift_r  <= '0;
            r_underrun <= 1'b1;
          end
        end else if (w_data_slot) begin
          // Shift the active channel MSB first; the idle channel keeps its word
          if (w_right_nxt) begin
            r_sdout   <= r_shift_r[width_p-1];
            r_shift_r <= r_shift_r <<< 1;
          end else begin
            r_sdout   <= r_shift_l[width_p-1];
            r_shift_l <= r_shift_l <<< 1;
          end
        end else begin
          r_sdout <= 1'b0;
        end
      end
      // Accept only happens while empty, so it never collides with the load clearing full
      if (w_accept) begin
        r_full <= 1'b1;
      end
    end
  end

  // Holding register captures an accepted pair; contents are meaningless while empty
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_hold_l <= data_l_i;
      r_hold_r <= data_r_i;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with default parameters (W=24, F=32, D=4).
// Each frame is decoded by sampling sdout_o on sclk_o rising edges and compared
// against a 64-bit slot image built from the pair that should be on the bus.
module tb_i2s_tx;

  logic               clk;
  logic               reset_i;
  logic signed [23:0] data_l;
  logic signed [23:0] data_r;
  logic               valid_i;
  logic               ready_o;
  logic               sclk_o;
  logic               lrclk_o;
  logic               sdout_o;
  logic               underrun_o;

  int n_chk  = 0;
  int n_pass = 0;
  int feed_idx;

  logic [23:0] pl [0:5];
  logic [23:0] pr [0:5];

  logic [63:0] v;
  int nb, ll, un, na, rh;

  i2s_tx #(.width_p(24), .frame_bits_p(32), .sclk_div_p(4)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .data_l_i   (data_l),
    .data_r_i   (data_r),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sclk_o     (sclk_o),
    .lrclk_o    (lrclk_o),
    .sdout_o    (sdout_o),
    .underrun_o (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Slot image, first SCLK of the frame in bit 63: delay bit, 24 data bits, 7 pad bits per channel
  function automatic logic [63:0] frame_vec(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  // Starting #1 after a frame-start edge, observe 256 cycles and end #1 after the next one
  task automatic run_frame(input bit feed, input bit late,
                           output logic [63:0] vec, output int nbits, output int lr_low,
                           output int und, output int nacc, output int rdy_hi);
    logic prev;
    bit   w;
    vec    = '0;
    nbits  = 0;
    nacc   = 0;
    prev   = sclk_o;
    lr_low = (lrclk_o == 1'b0) ? 1 : 0;
    und    = (underrun_o == 1'b1) ? 1 : 0;
    rdy_hi = (ready_o == 1'b1) ? 1 : 0;
    for (int i = 1; i <= 256; i++) begin
      w = valid_i & ready_o;
      @(posedge clk);
      #1;
      if (sclk_o && !prev) begin
        if (nbits < 64) vec[63-nbits] = sdout_o;
        nbits++;
      end
      prev = sclk_o;
      if (i < 256) begin
        if (lrclk_o == 1'b0) lr_low++;
        if (underrun_o == 1'b1) und++;
        if (ready_o == 1'b1) rdy_hi++;
      end
      if (feed && w) begin
        nacc++;
        feed_idx++;
        if (feed_idx < 4) begin
          data_l = pl[feed_idx];
          data_r = pr[feed_idx];
        end else begin
          valid_i = 1'b0;
        end
      end
      if (late && i == 255) begin
        valid_i = 1'b1;
        data_l  = pl[4];
        data_r  = pr[4];
      end
      if (late && i == 256) valid_i = 1'b0;
    end
  endtask

  initial begin
    pl[0] = 24'hF00010; pr[0] = 24'h00FF00;
    pl[1] = 24'hF00011; pr[1] = 24'h00FF01;
    pl[2] = 24'hF00012; pr[2] = 24'h00FF02;
    pl[3] = 24'hF00013; pr[3] = 24'h00FF03;
    pl[4] = 24'h800001; pr[4] = 24'h5A5A5A;
    pl[5] = 24'h3C3C3C; pr[5] = 24'h7F00C3;
    feed_idx = 0;
    reset_i  = 1'b1;
    valid_i  = 1'b0;
    data_l   = '0;
    data_r   = '0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk",     64'(sclk_o),     64'd0);
    chk("rst_lrclk",    64'(lrclk_o),    64'd1);
    chk("rst_sdout",    64'(sdout_o),    64'd0);
    chk("rst_ready",    64'(ready_o),    64'd0);
    chk("rst_underrun", 64'(underrun_o), 64'd0);
    reset_i = 1'b0;
    #1;
    chk("rel_ready", 64'(ready_o), 64'd1);

    // Pair presented before frame 0
    valid_i = 1'b1;
    data_l  = 24'hABCDEF;
    data_r  = 24'h123456;
    @(posedge clk);
    #1;
    chk("acc_ready_low", 64'(ready_o), 64'd0);
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("f0_lrclk_start", 64'(lrclk_o), 64'd0);
    run_frame(1'b0, 1'b0, v, nb, ll, un, na, rh);
    chk("f0_data",   v,        frame_vec(24'hABCDEF, 24'h123456));
    chk("f0_nbits",  64'(nb),  64'd64);
    chk("f0_lr_low", 64'(ll),  64'd128);
    chk("f0_und",    64'(un),  64'd0);

    // No data offered: silent frames, one underrun each
    for (int f = 1; f <= 2; f++) begin
      run_frame(1'b0, 1'b0, v, nb, ll, un, na, rh);
      chk("idle_data",   v,       64'd0);
      chk("idle_und",    64'(un), 64'd1);
      chk("idle_lr_low", 64'(ll), 64'd128);
    end

    // valid held high with a stream of four pairs
    valid_i = 1'b1;
    data_l  = pl[0];
    data_r  = pr[0];
    run_frame(1'b1, 1'b0, v, nb, ll, un, na, rh);
    chk("f3_data", v,        64'd0);
    chk("f3_und",  64'(un),  64'd1);
    chk("f3_nacc", 64'(na),  64'd1);
    chk("f3_rdy",  64'(rh),  64'd1);
    for (int k = 0; k < 3; k++) begin
      run_frame(1'b1, 1'b0, v, nb, ll, un, na, rh);
      chk("strm_data", v,       frame_vec(pl[k], pr[k]));
      chk("strm_und",  64'(un), 64'd0);
      chk("strm_nacc", 64'(na), 64'd1);
      chk("strm_rdy",  64'(rh), 64'd1);
    end
    run_frame(1'b1, 1'b0, v, nb, ll, un, na, rh);
    chk("f7_data", v,       frame_vec(pl[3], pr[3]));
    chk("f7_und",  64'(un), 64'd0);
    chk("f7_nacc", 64'(na), 64'd0);

    // Pair offered only in the frame-load cycle while empty
    run_frame(1'b0, 1'b1, v, nb, ll, un, na, rh);
    chk("f8_data", v,       64'd0);
    chk("f8_und",  64'(un), 64'd1);
    chk("late_ready_low", 64'(ready_o), 64'd0);
    run_frame(1'b0, 1'b0, v, nb, ll, un, na, rh);
    chk("f9_data", v,       64'd0);
    chk("f9_und",  64'(un), 64'd1);
    chk("f9_rdy",  64'(rh), 64'd0);

    // Late pair appears here; pair 5 accepted at the start of this frame
    valid_i = 1'b1;
    data_l  = pl[5];
    data_r  = pr[5];
    run_frame(1'b1, 1'b0, v, nb, ll, un, na, rh);
    chk("f10_data", v,       frame_vec(pl[4], pr[4]));
    chk("f10_und",  64'(un), 64'd0);
    chk("f10_nacc", 64'(na), 64'd1);

    // Frame 11 sends pair 5; hold another pair, then reset mid right slot
    chk("f11_und", 64'(underrun_o), 64'd0);
    valid_i = 1'b1;
    data_l  = pl[4];
    data_r  = pr[4];
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("f11_held", 64'(ready_o), 64'd0);
    repeat (160) @(posedge clk);
    #1;
    chk("mid_lrclk", 64'(lrclk_o), 64'd1);
    chk("mid_sdout", 64'(sdout_o), 64'd1);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_sclk",     64'(sclk_o),     64'd0);
    chk("mrst_lrclk",    64'(lrclk_o),    64'd1);
    chk("mrst_sdout",    64'(sdout_o),    64'd0);
    chk("mrst_underrun", 64'(underrun_o), 64'd0);
    chk("mrst_ready",    64'(ready_o),    64'd0);
    reset_i = 1'b0;
    #1;
    chk("mrel_ready", 64'(ready_o), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    run_frame(1'b0, 1'b0, v, nb, ll, un, na, rh);
    chk("post_data",   v,       64'd0);
    chk("post_und",    64'(un), 64'd1);
    chk("post_lr_low", 64'(ll), 64'd128);
    run_frame(1'b0, 1'b0, v, nb, ll, un, na, rh);
    chk("post2_data", v,       64'd0);
    chk("post2_und",  64'(un), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
